// File: rtl/imem_responder.sv
// Instruction memory responder: fixed-latency, single-outstanding fetch port with
// a preload write port, flush cancel and misaligned/out-of-range error reporting.
module imem_responder #(
  parameter int unsigned LATENCY = 2,
  parameter int unsigned DEPTH   = 512
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [15:0] addr,
  input  logic        flush,
  input  logic        wr_en,
  input  logic [15:0] wr_addr,
  input  logic [15:0] wr_data,
  output logic        ready,
  output logic        valid,
  output logic [15:0] instruction,
  output logic        err
);

  localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [2:0]  CNT_LOAD = 3'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, state_nx;
  logic [2:0]  cnt, cnt_nx;
  logic [15:0] addr_q, addr_nx;
  logic        do_read;
  logic [15:0] rd_addr;
  logic [14:0] rd_idx;
  logic        rd_oob;
  logic        wr_hit;
  logic        unused_wr_lsb;
  logic [15:0] mem [DEPTH];

  assign ready         = (state == IDLE);
  assign valid         = (state == RESP);
  // LATENCY=1 reads on the accepting edge, so the live address is used in IDLE
  assign rd_addr       = (state == IDLE) ? addr : addr_q;
  assign rd_idx        = rd_addr[15:1];
  assign rd_oob        = 32'(rd_idx) >= DEPTH;
  assign wr_hit        = wr_en && (32'(wr_addr[15:1]) < DEPTH);
  assign unused_wr_lsb = wr_addr[0];

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    addr_nx  = addr_q;
    do_read  = 1'b0;
    case (state)
      IDLE: begin
        if (req && !flush) begin
          addr_nx = addr;
          if (LATENCY == 1) begin
            do_read  = 1'b1;
            state_nx = RESP;
          end else begin
            cnt_nx   = CNT_LOAD;
            state_nx = WAIT;
          end
        end
      end
      WAIT: begin
        if (flush) begin
          cnt_nx   = '0;
          state_nx = IDLE;
        end else begin
          // read on the edge that brings the counter to zero: valid lands in cycle LATENCY
          cnt_nx = cnt - 3'd1;
          if (cnt == 3'd1) begin
            do_read  = 1'b1;
            state_nx = RESP;
          end
        end
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      addr_q      <= '0;
      instruction <= '0;
      err         <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      addr_q <= addr_nx;
      if (do_read) begin
        instruction <= rd_oob ? 16'hF000 : mem[rd_idx[AW-1:0]];
        err         <= rd_oob | rd_addr[0];
      end
    end
  end

  // storage is never reset; nonblocking write gives read-old on a same-edge collision
  always_ff @(posedge clk) begin
    if (wr_hit) mem[wr_addr[AW:1]] <= wr_data;
  end

endmodule

// File: tb/tb_imem_responder.sv
// Self-checking bench for imem_responder: directed scenarios plus randomized fetches
// against a word-array reference model, on a LATENCY=2 and a LATENCY=1 instance.
module tb_imem_responder;

  localparam int unsigned L0 = 2;
  localparam int unsigned L1 = 1;
  localparam int unsigned DEPTH_M = 512;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, flush0, req1, flush1;
  logic [15:0] addr0, addr1;
  logic        wr_en;
  logic [15:0] wr_addr, wr_data;
  logic        ready0, valid0, err0, ready1, valid1, err1;
  logic [15:0] instr0, instr1;

  logic [15:0] model [DEPTH_M];
  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  imem_responder #(.LATENCY(L0), .DEPTH(DEPTH_M)) u_dut0 (
    .clk(clk), .rst(rst), .req(req0), .addr(addr0), .flush(flush0),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .ready(ready0), .valid(valid0), .instruction(instr0), .err(err0)
  );

  imem_responder #(.LATENCY(L1), .DEPTH(DEPTH_M)) u_dut1 (
    .clk(clk), .rst(rst), .req(req1), .addr(addr1), .flush(flush1),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .ready(ready1), .valid(valid1), .instruction(instr1), .err(err1)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [15:0] exp_instr(input logic [15:0] a);
    if (int'(a >> 1) >= int'(DEPTH_M)) return 16'hF000;
    return model[a[9:1]];
  endfunction

  function automatic logic exp_err(input logic [15:0] a);
    return a[0] | (int'(a >> 1) >= int'(DEPTH_M));
  endfunction

  function automatic logic o_ready(input bit sel);
    return sel ? ready1 : ready0;
  endfunction

  function automatic logic o_valid(input bit sel);
    return sel ? valid1 : valid0;
  endfunction

  function automatic logic [15:0] o_instr(input bit sel);
    return sel ? instr1 : instr0;
  endfunction

  function automatic logic o_err(input bit sel);
    return sel ? err1 : err0;
  endfunction

  task automatic drive_req(input bit sel, input logic r, input logic [15:0] a);
    if (sel) begin req1 = r; addr1 = a; end
    else     begin req0 = r; addr0 = a; end
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick;
    wr_en = 1'b0;
    if (int'(a >> 1) < int'(DEPTH_M)) model[a[9:1]] = d;
  endtask

  // one request; valid must appear in cycle LATENCY counting the cycle after acceptance as 1
  task automatic fetch(input bit sel, input logic [15:0] a, input string tag);
    logic [15:0] ei;
    logic        ee;
    int          cyc;
    int unsigned lat;
    lat = sel ? L1 : L0;
    ei  = exp_instr(a);
    ee  = exp_err(a);
    drive_req(sel, 1'b1, a);
    tick;
    drive_req(sel, 1'b0, 16'h0000);
    cyc = 1;
    chk({tag, "_ready_low"}, 32'(o_ready(sel)), 32'(0));
    while (!o_valid(sel) && cyc < 16) begin
      tick;
      cyc++;
    end
    chk({tag, "_latency"}, 32'(cyc), 32'(lat));
    chk({tag, "_instr"}, 32'(o_instr(sel)), 32'(ei));
    chk({tag, "_err"}, 32'(o_err(sel)), 32'(ee));
    tick;
    chk({tag, "_valid_1cyc"}, 32'(o_valid(sel)), 32'(0));
    chk({tag, "_ready_back"}, 32'(o_ready(sel)), 32'(1));
  endtask

  task automatic expect_quiet(input bit sel, input string tag);
    int seen;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (o_valid(sel)) seen++;
      tick;
    end
    chk({tag, "_no_valid"}, 32'(seen), 32'(0));
    chk({tag, "_ready"}, 32'(o_ready(sel)), 32'(1));
  endtask

  initial begin
    int          nv, cyc;
    int          tv [2];
    logic [15:0] iv [2];
    logic [15:0] a;
    int unsigned r;

    rst = 1'b1; req0 = 0; req1 = 0; flush0 = 0; flush1 = 0;
    addr0 = '0; addr1 = '0; wr_en = 0; wr_addr = '0; wr_data = '0;
    tick; tick;
    rst = 1'b0;
    chk("rst_ready0", 32'(ready0), 32'(1));
    chk("rst_valid0", 32'(valid0), 32'(0));
    chk("rst_instr0", 32'(instr0), 32'(0));
    chk("rst_err0",   32'(err0),   32'(0));
    chk("rst_ready1", 32'(ready1), 32'(1));
    chk("rst_instr1", 32'(instr1), 32'(0));

    for (int i = 0; i < int'(DEPTH_M); i++) wr(16'(i * 2), 16'($urandom));
    wr(16'h0006, 16'h1234);
    wr(16'h0000, 16'hA001);
    wr(16'h0002, 16'hA002);
    wr(16'h0800, 16'hDEAD);  // out of range, must be discarded

    fetch(0, 16'h0006, "basic");

    // request held high: second address only taken once the first response is done
    req0 = 1'b1; addr0 = 16'h0000;
    tick;
    addr0 = 16'h0002;
    cyc = 1; nv = 0; tv = '{0, 0}; iv = '{16'h0, 16'h0};
    while (nv < 2 && cyc < 30) begin
      if (valid0) begin
        tv[nv] = cyc; iv[nv] = instr0; nv++;
      end
      if (nv < 2) begin tick; cyc++; end
    end
    req0 = 1'b0;
    chk("b2b_count",   32'(nv),            32'(2));
    chk("b2b_first",   32'(tv[0]),         32'(L0));
    chk("b2b_spacing", 32'(tv[1] - tv[0]), 32'(L0 + 1));
    chk("b2b_data0",   32'(iv[0]),         32'h0000A001);
    chk("b2b_data1",   32'(iv[1]),         32'h0000A002);
    tick;

    fetch(0, 16'h0007, "odd");
    fetch(0, 16'h0400, "oob");
    fetch(0, 16'hFFFF, "oob_odd");

    req0 = 1'b1; addr0 = 16'h0006;
    tick;
    req0 = 1'b0; flush0 = 1'b1;
    tick;
    flush0 = 1'b0;
    expect_quiet(0, "flush_wait");
    fetch(0, 16'h0006, "after_flush");

    req0 = 1'b1; flush0 = 1'b1; addr0 = 16'h0006;
    tick;
    req0 = 1'b0; flush0 = 1'b0;
    chk("flush_beats_req", 32'(ready0), 32'(1));
    expect_quiet(0, "flush_idle");

    req0 = 1'b1; addr0 = 16'h0006;
    tick;
    req0 = 1'b0; rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("rstw_valid", 32'(valid0), 32'(0));
    chk("rstw_instr", 32'(instr0), 32'(0));
    chk("rstw_ready", 32'(ready0), 32'(1));
    expect_quiet(0, "rstw");
    fetch(0, 16'h0006, "after_rst");

    for (int it = 0; it < 40; it++) begin
      r = $urandom_range(0, 9);
      if (r < 6)      a = {6'b0, 9'($urandom_range(0, DEPTH_M - 1)), 1'b0};
      else if (r < 8) a = {6'b0, 9'($urandom_range(0, DEPTH_M - 1)), 1'b1};
      else            a = 16'($urandom_range(DEPTH_M * 2, 16'hFFFF));
      if ($urandom_range(0, 2) == 0) wr({6'b0, 9'($urandom), 1'b0}, 16'($urandom));
      if ($urandom_range(0, 5) == 0) begin
        req0 = 1'b1; addr0 = a;
        tick;
        req0 = 1'b0; flush0 = 1'b1;
        tick;
        flush0 = 1'b0;
        expect_quiet(0, "rnd_flush");
      end else begin
        fetch(0, a, "rnd");
      end
    end

    fetch(1, 16'h0006, "l1_basic");
    req1 = 1'b1; addr1 = 16'h0006;
    wr_en = 1'b1; wr_addr = 16'h0006; wr_data = 16'hBEEF;
    tick;
    req1 = 1'b0; wr_en = 1'b0;
    chk("l1_coll_valid", 32'(valid1), 32'(1));
    chk("l1_coll_old",   32'(instr1), 32'h00001234);
    model[3] = 16'hBEEF;
    tick;
    fetch(1, 16'h0006, "l1_new");
    fetch(1, 16'h0401, "l1_oob");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
